acia_6551: RTL and testbench



---
 rtl/acia_6551.sv | 278 +++++++++++++++++++++++++++
 tb/tb_acia_6551.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_6551.sv
// 6551-style ACIA: four CPU-visible registers plus one async 8-bit TX/RX pair, level IRQ.
// Define ACIA_PARITY_EN to add a parity bit under control of CMD[7:5]; otherwise frames are 8N1.
module acia_6551 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       CS,
  input  logic       RWN,
  input  logic [1:0] RS,
  input  logic [7:0] DATAIN,
  output logic [7:0] DATAOUT,
  output logic       RTSB,
  input  logic       CTSB,
  output logic       DTRB,
  input  logic       RXD,
  output logic       TXD,
  output logic       IRQn
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  // Register file
  logic [7:0] cmd;
  logic [7:0] ctrl;
  logic [7:0] tdr;
  logic [7:0] rdr;
  logic       tdre;
  logic       rdrf;
  logic       ovr;
  logic       fe;
  logic       pe;
  logic       irq;

  logic       rd_rdr;
  logic       rd_stat;
  logic       wr_tdr;
  logic       wr_prst;
  logic       wr_cmd;
  logic       wr_ctrl;
  logic       brk;
  logic       par_en;

  assign rd_rdr  = !CS &&  RWN && (RS == 2'd0);
  assign rd_stat = !CS &&  RWN && (RS == 2'd1);
  assign wr_tdr  = !CS && !RWN && (RS == 2'd0);
  assign wr_prst = !CS && !RWN && (RS == 2'd1);
  assign wr_cmd  = !CS && !RWN && (RS == 2'd2);
  assign wr_ctrl = !CS && !RWN && (RS == 2'd3);

  assign brk  = (cmd[3:2] == 2'b11);
  assign RTSB = (cmd[3:2] == 2'b00);
  assign DTRB = ~cmd[0];
  assign IRQn = ~irq;

`ifdef ACIA_PARITY_EN
  assign par_en = cmd[5];
`else
  assign par_en = 1'b0;
`endif

  // mode: 00 odd, 01 even, 10 mark, 11 space
  function automatic logic par_bit(input logic [1:0] mode, input logic [7:0] d);
    logic p;
    unique case (mode)
      2'b00: p = ~^d;
      2'b01: p = ^d;
      2'b10: p = 1'b1;
      2'b11: p = 1'b0;
    endcase
    return p;
  endfunction

  always_comb begin
    DATAOUT = 8'h00;
    unique case (RS)
      2'd0: DATAOUT = rdr;
      2'd1: DATAOUT = {irq, 2'b00, tdre, rdrf, ovr, fe, pe};
      2'd2: DATAOUT = cmd;
      2'd3: DATAOUT = ctrl;
    endcase
  end

  // ---------------- Transmitter ----------------
  typedef enum logic {TxIdle, TxShift} tx_state_e;

  tx_state_e       tx_state;
  logic [CntW-1:0] tx_cnt;
  logic [3:0]      tx_left;
  logic [9:0]      tx_sh;
  logic            tx_load;

  // A pending byte waits for an idle shifter, asserted CTS and no break.
  assign tx_load = (tx_state == TxIdle) && !tdre && !CTSB && !brk;

  always_ff @(posedge PHI2) begin
    if (!RESET) begin
      tx_state <= TxIdle;
      tx_cnt   <= '0;
      tx_left  <= 4'd0;
      tx_sh    <= '0;
      TXD      <= 1'b1;
    end else begin
      unique case (tx_state)
        TxIdle: begin
          tx_cnt <= '0;
          if (tx_load) begin
            tx_state <= TxShift;
            TXD      <= 1'b0;
            if (par_en) begin
              tx_sh   <= {1'b1, par_bit(cmd[7:6], tdr), tdr};
              tx_left <= 4'd10;
            end else begin
              tx_sh   <= {2'b11, tdr};
              tx_left <= 4'd9;
            end
          end else begin
            TXD <= ~brk;
          end
        end
        TxShift: begin
          if (tx_cnt == BitLast) begin
            tx_cnt <= '0;
            if (tx_left == 4'd0) begin
              tx_state <= TxIdle;
              TXD      <= ~brk;
            end else begin
              TXD     <= tx_sh[0];
              tx_sh   <= {1'b1, tx_sh[9:1]};
              tx_left <= tx_left - 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CntW'(1);
          end
        end
      endcase
    end
  end

  // ---------------- Receiver ----------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  rx_state_e       rx_state;
  logic            rx_s1;
  logic            rx_s2;
  logic            rx_prev;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_sh;
  logic            rx_par;
  logic            rx_done;
  logic            rx_fe;
  logic            rx_pe;

  always_ff @(posedge PHI2) begin
    if (!RESET) begin
      rx_state <= RxIdle;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_sh    <= 8'h00;
      rx_par   <= 1'b0;
      rx_done  <= 1'b0;
      rx_fe    <= 1'b0;
      rx_pe    <= 1'b0;
    end else begin
      rx_s1   <= RXD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RxStart;
        end
        RxStart: begin
          // Half a bit in: still low means a real start bit, otherwise a glitch.
          if (rx_cnt == HalfLast) begin
            rx_cnt   <= '0;
            rx_idx   <= 3'd0;
            rx_state <= rx_s2 ? RxIdle : RxData;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        RxData: begin
          if (rx_cnt == BitLast) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= par_en ? RxParity : RxStop;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        RxParity: begin
          if (rx_cnt == BitLast) begin
            rx_cnt   <= '0;
            rx_par   <= rx_s2;
            rx_state <= RxStop;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt == BitLast) begin
            rx_cnt   <= '0;
            rx_done  <= 1'b1;
            rx_fe    <= ~rx_s2;
            rx_pe    <= par_en && !cmd[7] && (rx_par != par_bit(cmd[7:6], rx_sh));
            rx_state <= RxIdle;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------- Register updates ----------------
  logic rx_load;
  logic irq_set;

  // A read of RDR in the same cycle frees the buffer for the arriving byte.
  assign rx_load = rx_done && !(rdrf && !rd_rdr);
  assign irq_set = (rx_load && !cmd[1]) || (tx_load && !wr_tdr && (cmd[3:2] == 2'b01));

  always_ff @(posedge PHI2) begin
    if (!RESET) begin
      cmd  <= 8'h02;
      ctrl <= 8'h00;
      tdr  <= 8'h00;
      rdr  <= 8'h00;
      tdre <= 1'b1;
      rdrf <= 1'b0;
      ovr  <= 1'b0;
      fe   <= 1'b0;
      pe   <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (tx_load) tdre <= 1'b1;
      if (wr_tdr) begin
        tdr  <= DATAIN;
        tdre <= 1'b0;
      end
      if (wr_prst) begin
        cmd[4:0] <= 5'b00010;
        ovr      <= 1'b0;
      end
      if (wr_cmd)  cmd  <= DATAIN;
      if (wr_ctrl) ctrl <= DATAIN;
      if (rd_rdr) begin
        rdrf <= 1'b0;
        ovr  <= 1'b0;
        fe   <= 1'b0;
        pe   <= 1'b0;
      end
      if (rx_done) begin
        if (rx_load) begin
          rdr  <= rx_sh;
          rdrf <= 1'b1;
          fe   <= rx_fe;
          pe   <= rx_pe;
        end else begin
          ovr <= 1'b1;
        end
      end
      if (rd_stat) irq <= 1'b0;
      if (irq_set) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acia_6551.sv
// Directed bench for acia_6551 with a register/status model and a serial-line frame checker.
module tb_acia_6551;
  localparam int unsigned Cpb = 16;

  logic       PHI2 = 1'b0;
  logic       RESET = 1'b0;
  logic       CS = 1'b1;
  logic       RWN = 1'b1;
  logic [1:0] RS = 2'd0;
  logic [7:0] DATAIN = 8'h00;
  logic [7:0] DATAOUT;
  logic       RTSB;
  logic       CTSB = 1'b1;
  logic       DTRB;
  logic       RXD = 1'b1;
  logic       TXD;
  logic       IRQn;

  acia_6551 #(.CLKS_PER_BIT(Cpb)) dut (
    .PHI2(PHI2), .RESET(RESET), .CS(CS), .RWN(RWN), .RS(RS), .DATAIN(DATAIN),
    .DATAOUT(DATAOUT), .RTSB(RTSB), .CTSB(CTSB), .DTRB(DTRB), .RXD(RXD), .TXD(TXD),
    .IRQn(IRQn)
  );

  always #5 PHI2 = ~PHI2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [7:0] m_cmd, m_ctrl, m_rdr;
  logic       m_tdre, m_rdrf, m_ovr, m_fe, m_pe, m_irq;

  function automatic logic [7:0] m_status();
    return {m_irq, 2'b00, m_tdre, m_rdrf, m_ovr, m_fe, m_pe};
  endfunction

  function automatic logic m_par_on();
`ifdef ACIA_PARITY_EN
    return m_cmd[5];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_par(input logic [1:0] mode, input logic [7:0] d);
    case (mode)
      2'b00:   return ~^d;
      2'b01:   return ^d;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_cmd = 8'h02; m_ctrl = 8'h00; m_rdr = 8'h00;
    m_tdre = 1'b1; m_rdrf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_rx(input logic [7:0] d, input logic stop, input logic pbit);
    if (m_rdrf) m_ovr = 1'b1;
    else begin
      m_rdr = d; m_rdrf = 1'b1; m_fe = ~stop;
      m_pe = m_par_on() && !m_cmd[7] && (pbit != exp_par(m_cmd[7:6], d));
      if (!m_cmd[1]) m_irq = 1'b1;
    end
  endtask

  task automatic model_tx_start();
    m_tdre = 1'b1;
    if (m_cmd[3:2] == 2'b01) m_irq = 1'b1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Modem lines follow the command register every cycle.
  always @(negedge PHI2) begin
    if (chk_en) begin
      check("RTSB", {7'd0, RTSB}, {7'd0, m_cmd[3:2] == 2'b00});
      check("DTRB", {7'd0, DTRB}, {7'd0, ~m_cmd[0]});
    end
  end

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] d);
    @(negedge PHI2);
    CS = 1'b0; RWN = 1'b0; RS = rs; DATAIN = d;
    @(posedge PHI2); #1;
    CS = 1'b1; RWN = 1'b1;
    case (rs)
      2'd0: m_tdre = 1'b0;
      2'd1: begin m_cmd[4:0] = 5'b00010; m_ovr = 1'b0; end
      2'd2: m_cmd = d;
      default: m_ctrl = d;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] rs, output logic [7:0] d);
    @(negedge PHI2);
    CS = 1'b0; RWN = 1'b1; RS = rs;
    #1 d = DATAOUT;
    @(posedge PHI2); #1;
    CS = 1'b1;
    if (rs == 2'd0) begin m_rdrf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; end
    if (rs == 2'd1) m_irq = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] rs, input logic [7:0] req);
    logic [7:0] d;
    bus_read(rs, d);
    check(name, d, req);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, output int nbits);
    if (m_par_on()) begin
      nbits = 11;
      return {1'b1, exp_par(m_cmd[7:6], d), d, 1'b0};
    end
    nbits = 10;
    return {2'b11, d, 1'b0};
  endfunction

  // Waits (bounded) for a start bit, then checks every cycle of every bit.
  task automatic expect_tx(input string name, input logic [10:0] bits, input int nbits,
                           input int bound);
    int waited = 0;
    while (TXD !== 1'b0 && waited < bound) begin
      @(posedge PHI2); #1; waited++;
    end
    n_cmp++;
    if (TXD !== 1'b0) begin
      n_err++;
      $display("FAIL %s start: TXD=%b, want 0 within %0d cycles", name, TXD, bound);
      return;
    end
    model_tx_start();
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        if (b != 0 || c != 0) begin
          @(posedge PHI2); #1;
        end
        check($sformatf("%s bit%0d", name, b), {7'd0, TXD}, {7'd0, bits[b]});
      end
    end
  endtask

  task automatic hold_txd(input string name, input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge PHI2); #1;
      check(name, {7'd0, TXD}, {7'd0, v});
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic has_par,
                         input logic pbit);
    logic [10:0] seq;
    int n;
    seq = {stop, pbit, d, 1'b0};
    if (!has_par) seq = {1'b1, stop, d, 1'b0};
    n = has_par ? 11 : 10;
    for (int b = 0; b < n; b++) begin
      @(negedge PHI2);
      RXD = seq[b];
      repeat (Cpb - 1) @(negedge PHI2);
    end
    @(negedge PHI2);
    RXD = 1'b1;
    repeat (4) @(negedge PHI2);
    model_rx(d, stop, pbit);
  endtask

  logic [10:0] fb;
  int          fn;

  initial begin
    model_reset();
    repeat (3) @(posedge PHI2);
    @(negedge PHI2);
    RESET = 1'b1;
    chk_en = 1'b1;

    // Reset state
    #1;
    check("reset TXD", {7'd0, TXD}, 8'd1);
    check("reset IRQn", {7'd0, IRQn}, {7'd0, ~m_irq});
    read_check("reset STATUS", 2'd1, 8'h10);
    read_check("reset CMD", 2'd2, 8'h02);
    read_check("reset CTRL", 2'd3, m_ctrl);
    read_check("reset RDR", 2'd0, m_rdr);

    // Transmit 0xA5 with DTR on, RTS on, TX IRQ off
    CTSB = 1'b0;
    bus_write(2'd2, 8'h0B);
    bus_write(2'd0, 8'hA5);
    expect_tx("tx A5", 11'b01_1010_0101_0, 10, 4);
    read_check("tx A5 STATUS", 2'd1, m_status());
    check("tx A5 TDRE", {7'd0, m_tdre}, 8'd1);

    // Receive 0x3C with RX IRQ enabled
    bus_write(2'd2, 8'h09);
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    check("rx 3C IRQn", {7'd0, IRQn}, {7'd0, ~m_irq});
    read_check("rx 3C STATUS", 2'd1, 8'h98);
    @(negedge PHI2);
    check("rx 3C IRQn cleared", {7'd0, IRQn}, 8'd1);
    read_check("rx 3C RDR", 2'd0, 8'h3C);
    read_check("rx 3C STATUS after", 2'd1, m_status());

    // Overrun: second byte lost, first kept
    send_rx(8'h11, 1'b1, 1'b0, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0, 1'b0);
    read_check("ovr STATUS", 2'd1, m_status());
    read_check("ovr RDR", 2'd0, 8'h11);
    read_check("ovr cleared STATUS", 2'd1, m_status());

    // Framing error
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    read_check("fe STATUS", 2'd1, m_status());
    read_check("fe RDR", 2'd0, 8'h55);
    read_check("fe cleared STATUS", 2'd1, m_status());

    // Programmed reset keeps CMD[7:5]
    bus_write(2'd2, 8'hE5);
    bus_write(2'd3, 8'h5A);
    read_check("CMD E5", 2'd2, m_cmd);
    bus_write(2'd1, 8'hFF);
    read_check("prog reset CMD", 2'd2, 8'hE2);
    read_check("prog reset CTRL", 2'd3, 8'h5A);

    // CTS gating and TX IRQ on TDRE rise
    CTSB = 1'b1;
    bus_write(2'd2, 8'h05);
    bus_write(2'd0, 8'h3A);
    hold_txd("cts held TXD", 1'b1, 40);
    read_check("cts STATUS", 2'd1, m_status());
    @(negedge PHI2);
    CTSB = 1'b0;
    fb = frame_of(8'h3A, fn);
    expect_tx("tx 3A", fb, fn, 2);
    check("tx 3A IRQn", {7'd0, IRQn}, {7'd0, ~m_irq});
    read_check("tx 3A STATUS", 2'd1, 8'h90);

    // Break holds TXD low and keeps the pending byte
    bus_write(2'd2, 8'h0D);
    hold_txd("break TXD", 1'b0, 20);
    bus_write(2'd0, 8'h77);
    hold_txd("break pending TXD", 1'b0, 20);
    read_check("break STATUS", 2'd1, m_status());
    @(negedge PHI2);
    CTSB = 1'b1;
    bus_write(2'd2, 8'h09);
    hold_txd("break released TXD", 1'b1, 5);
    @(negedge PHI2);
    CTSB = 1'b0;
    fb = frame_of(8'h77, fn);
    expect_tx("tx 77", fb, fn, 2);

`ifdef ACIA_PARITY_EN
    // Even parity transmit and a receive with the wrong parity bit
    bus_write(2'd2, 8'h6B);
    bus_write(2'd0, 8'h01);
    expect_tx("tx par 01", 11'b1_1_00000001_0, 11, 4);
    send_rx(8'h01, 1'b1, 1'b1, 1'b0);
    read_check("rx par STATUS", 2'd1, 8'h19);
    read_check("rx par RDR", 2'd0, 8'h01);
`endif

    // Reset mid-frame forces the line idle on the next edge
    bus_write(2'd2, 8'h09);
    bus_write(2'd0, 8'h00);
    repeat (3 * Cpb) @(posedge PHI2);
    #1 check("mid-frame TXD low", {7'd0, TXD}, 8'd0);
    @(negedge PHI2);
    RESET = 1'b0;
    @(posedge PHI2); #1;
    model_reset();
    check("reset mid-frame TXD", {7'd0, TXD}, 8'd1);
    @(negedge PHI2);
    RESET = 1'b1;
    hold_txd("after reset TXD", 1'b1, 2 * Cpb);
    read_check("after reset STATUS", 2'd1, 8'h10);
    read_check("after reset CMD", 2'd2, m_cmd);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
